// File: rtl/canvas_i2c_master.sv
// canvas_i2c_master: single-byte I2C write master with open-drain line enables.
// Timing is built from quarter-period ticks that freeze while a slave stretches SCL.
module canvas_i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;
  state_t     state_q, state_d;
  logic [7:0] qc_q, qc_d, sh_q, sh_d, data_q, data_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d, done_q, done_d, nack_q, nack_d;
  logic       accept, stall, tick, ack_phase;
  assign accept    = cmd_valid && state_q == IDLE;
  assign stall     = !scl_oe_q && !scl_in;
  assign tick      = !stall && qc_q == 8'(CLK_DIV - 1);
  assign ack_phase = state_q == ADDR_ACK || state_q == DATA_ACK;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign nack      = nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  always_comb begin
    state_d = state_q;
    qc_d    = qc_q;
    qtr_d   = qtr_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = START;
      qc_d    = 8'd0;
      qtr_d   = 2'd0;
      cnt_d   = 3'd0;
      sh_d    = {cmd_addr, 1'b0};
      data_d  = cmd_data;
      nack_d  = 1'b0;
    end else if (state_q != IDLE && !stall) begin
      qc_d  = tick ? 8'd0 : qc_q + 8'd1;
      qtr_d = tick ? qtr_q + 2'd1 : qtr_q;
      if (tick && qtr_q == 2'd2 && ack_phase && sda_in) nack_d = 1'b1;
      if (tick && qtr_q == 2'd3) begin
        case (state_q)
          START: state_d = ADDR;
          ADDR, DATA: begin
            sh_d    = {sh_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            state_d = cnt_q != 3'd7 ? state_q : state_q == ADDR ? ADDR_ACK : DATA_ACK;
          end
          ADDR_ACK: begin
            sh_d    = data_q;
            state_d = nack_q ? STOP : DATA;
          end
          DATA_ACK: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  // line enables are decoded from the next phase/quarter so the pins come straight off flops
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      START: begin
        scl_oe_d = qtr_d == 2'd3;
        sda_oe_d = qtr_d[1];
      end
      ADDR, DATA: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ~sh_d[7];
      end
      ADDR_ACK, DATA_ACK: scl_oe_d = ~qtr_d[1];
      STOP: begin
        scl_oe_d = qtr_d == 2'd0;
        sda_oe_d = ~qtr_d[1];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      qc_q     <= 8'd0;
      qtr_q    <= 2'd0;
      cnt_q    <= 3'd0;
      sh_q     <= 8'd0;
      data_q   <= 8'd0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qc_q     <= qc_d;
      qtr_q    <= qtr_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end
endmodule

// File: tb/tb_canvas_i2c_master.sv
// tb_canvas_i2c_master: phase-table model checked every cycle, plus a bus-level slave
// that ACKs on command and captures the bits seen on SCL rising edges.
module tb_canvas_i2c_master;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, busy, done, nack, scl_in, sda_in, scl_oe, sda_oe;
  logic       hold = 1'b0;
  logic       slave_pull = 1'b0;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  bit         cfg_ack_a, cfg_ack_d;
  int         checks = 0, errors = 0, done_seen = 0;
  bit         m_act = 1'b0;
  int         m_t = 0, m_total = 0, m_nack = 0;
  int         ptype [20];
  bit         pbit [20];
  int         falls = 0, rises = 0;
  logic [31:0] rxbits = '0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         n, d1, d2, ds;
  logic [7:0] ra, rd;

  canvas_i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done), .nack(nack),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;
  assign scl_in = ~scl_oe & ~hold;
  assign sda_in = ~sda_oe & ~slave_pull;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  // slave: START resets counters; ACK is pulled for the 9th and 18th SCL low periods
  always @(negedge clk) begin
    if (p_scl && scl_in && p_sda && !sda_in) begin
      falls = 0;
      rises = 0;
      rxbits = '0;
      slave_pull = 1'b0;
    end else if (p_scl && !scl_in) begin
      falls++;
      slave_pull = (falls == 9 && cfg_ack_a) || (falls == 18 && cfg_ack_d);
    end else if (!p_scl && scl_in) begin
      if (rises < 31) rises++;
      rxbits[rises] = sda_in;
    end
    p_scl = scl_in;
    p_sda = sda_in;
  end

  // model: a transaction is a list of phases; effective time only advances when SCL is not held
  always @(negedge clk) begin : cmp
    int ph, q, es, ed;
    bit idle;
    if (!rst_n) begin
      m_act = 1'b0;
      m_nack = 0;
      chk("rst_scl_oe", scl_oe, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_nack", nack, 0);
    end else begin
      idle = !m_act || m_t == m_total;
      es = 0;
      ed = 0;
      if (!idle) begin
        ph = m_t / (4 * D);
        q  = (m_t % (4 * D)) / D;
        es = ptype[ph] == 0 ? int'(q == 3) : ptype[ph] == 3 ? int'(q == 0) : int'(q < 2);
        ed = ptype[ph] == 0 ? int'(q >= 2) : ptype[ph] == 1 ? int'(!pbit[ph]) :
             ptype[ph] == 2 ? 0 : int'(q < 2);
        if (m_t == 0) chk("nack_on_accept", nack, 0);
      end else chk("nack", nack, m_nack);
      chk("scl_oe", scl_oe, es);
      chk("sda_oe", sda_oe, ed);
      chk("busy", busy, !idle);
      chk("cmd_ready", cmd_ready, idle);
      chk("done", done, m_act && m_t == m_total);
      if (done) done_seen++;
      if (idle && cmd_valid) begin
        m_act = 1'b1;
        m_t = 0;
        ptype[0] = 0;
        for (int i = 0; i < 8; i++) begin
          ptype[1 + i] = 1;
          pbit[1 + i] = i < 7 ? cmd_addr[6 - i] : 1'b0;
          ptype[10 + i] = 1;
          pbit[10 + i] = cmd_data[7 - i];
        end
        ptype[9] = 2;
        ptype[18] = 2;
        ptype[19] = 3;
        if (!cfg_ack_a) ptype[10] = 3;
        m_total = (cfg_ack_a ? 20 : 11) * 4 * D;
        m_nack = int'(!cfg_ack_a || !cfg_ack_d);
      end else if (idle) m_act = 1'b0;
      else if (es != 0 || scl_in) m_t++;
    end
  end

  task automatic wait_accept();
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", cmd_ready, 1);
    @(posedge clk);
  endtask

  task automatic grab(output logic [7:0] a_o, output logic [7:0] d_o);
    for (int i = 0; i < 8; i++) begin
      a_o[7 - i] = rxbits[1 + i];
      d_o[7 - i] = rxbits[10 + i];
    end
  endtask

  task automatic run(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad,
                     input int hold_at, input int exp_lat, input bit exp_nack, input int exp_rises);
    int k = 0;
    logic [7:0] xa, xd;
    @(posedge clk);
    #1;
    cfg_ack_a = aa;
    cfg_ack_d = ad;
    cmd_addr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    wait_accept();
    #1 cmd_valid = 1'b0;
    chk("nack_cleared", nack, 0);
    chk("busy_after_accept", busy, 1);
    while (k < 2000) begin
      @(negedge clk);
      if (done) break;
      k++;
      @(posedge clk);
      #1 hold = hold_at >= 0 && k >= hold_at && k < hold_at + 20;
    end
    chk("latency", k, exp_lat);
    chk("nack_at_done", nack, exp_nack);
    grab(xa, xd);
    chk("scl_rises", rises, exp_rises);
    chk("rx_addr", xa, {a, 1'b0});
    if (aa) chk("rx_data", xd, d);
    @(negedge clk);
    chk("scl_released", scl_oe, 0);
    chk("sda_released", sda_oe, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    cfg_ack_a = 1'b1;
    cfg_ack_d = 1'b1;
    #12;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_scl", scl_oe, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run(7'h2A, 8'hC5, 1'b1, 1'b1, -1, 320, 1'b0, 19);
    run(7'h2A, 8'hC5, 1'b0, 1'b1, -1, 176, 1'b1, 10);
    run(7'h2A, 8'hC5, 1'b1, 1'b0, -1, 320, 1'b1, 19);
    run(7'h2A, 8'hC5, 1'b1, 1'b1, 88, 340, 1'b0, 19);
    // abort during DATA bit 5, quarter 1
    @(posedge clk);
    #1;
    cmd_addr = 7'h33;
    cmd_data = 8'h96;
    cmd_valid = 1'b1;
    wait_accept();
    #1 cmd_valid = 1'b0;
    repeat (196) @(posedge clk);
    #1;
    chk("pre_reset_scl", scl_oe, 1);
    chk("pre_reset_sda", sda_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_scl_oe", scl_oe, 0);
    chk("async_sda_oe", sda_oe, 0);
    chk("async_ready", cmd_ready, 1);
    chk("async_busy", busy, 0);
    ds = done_seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("no_done_on_abort", done_seen, ds);
    run(7'h55, 8'h0F, 1'b1, 1'b1, -1, 320, 1'b0, 19);
    // back-to-back with cmd_valid held
    @(posedge clk);
    #1;
    cmd_addr = 7'h11;
    cmd_data = 8'hA5;
    cmd_valid = 1'b1;
    ds = done_seen;
    wait_accept();
    #1 cmd_data = 8'h3C;
    n = 0;
    d1 = -1;
    d2 = -1;
    while (n < 1500 && d2 < 0) begin
      @(negedge clk);
      if (done && d1 < 0) begin
        d1 = n;
        chk("ready_with_done", cmd_ready, 1);
      end else if (done) d2 = n;
      n++;
      @(posedge clk);
      #1 if (d1 >= 0) cmd_valid = 1'b0;
    end
    chk("first_done", d1, 320);
    chk("done_spacing", d2 - d1, 321);
    grab(ra, rd);
    chk("rx_data_second", rd, 8'h3C);
    repeat (20) @(posedge clk);
    chk("done_count", done_seen - ds, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
